// File: rtl/serial_addsub_unit_pkg.sv
// Shared types and helpers for the serial add/subtract unit.
package serial_addsub_unit_pkg;

  // Controller states; encodings kept identical to the legacy defines.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Operation select values on the mode input.
  localparam logic MODE_SUB = 1'b0;
  localparam logic MODE_ADD = 1'b1;

  // Two's-complement overflow from the operand and result sign bits.
  function automatic logic ovf_flag(input logic mode, input logic a_msb,
                                    input logic b_msb, input logic r_msb);
    if (mode == MODE_ADD)
      return (a_msb == b_msb) && (r_msb != a_msb);
    else
      return (a_msb != b_msb) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/serial_addsub_unit_cell.sv
// One-bit combinational add/subtract cell used in the serial chain.
module addsub_cell
  import serial_addsub_unit_pkg::*;
(
  input  logic x,
  input  logic y,
  input  logic cin,
  input  logic mode,
  output logic s,
  output logic cout
);

  // Sum/difference bit and carry/borrow out of the selected operation.
  always_comb begin
    s = x ^ y ^ cin;
    if (mode == MODE_SUB)
      cout = (~x & y) | (~(x ^ y) & cin);
    else
      cout = (x & y) | ((x ^ y) & cin);
  end

endmodule

// File: rtl/serial_addsub_unit.sv
// Multi-cycle add/subtract unit: LSB-first, STEP bits per clock through a
// registered carry/borrow chain, with start/busy/done handshake and flags.
module serial_addsub_unit
  import serial_addsub_unit_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  localparam int NCYC = WIDTH / STEP;
  localparam int CW   = $clog2(NCYC) + 1;

  state_t           state_q, state_d;
  logic             load, shift, finish;

  logic [WIDTH-1:0] a_sr, b_sr, r_sr;
  logic             mode_q;
  logic             a_msb_q, b_msb_q;
  logic             chain_q;
  logic [CW-1:0]    cnt_q;
  logic             last_slice;

  logic [STEP-1:0]  slice;
  logic             chain_out;
  logic [WIDTH+STEP-1:0] r_ext;

  assign last_slice = (cnt_q == CW'(NCYC - 1));

  // Next-state and control strobes for the IDLE/RUN/DONE sequence.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    shift   = 1'b0;
    finish  = 1'b0;
    busy    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        shift = 1'b1;
        busy  = 1'b1;
        if (last_slice)
          state_d = ST_DONE;
      end
      ST_DONE: begin
        finish  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  // STEP chained cells; each generate block owns its carry so the ripple is
  // a chain of distinct nets rather than one self-referencing vector.
  for (genvar i = 0; i < STEP; i++) begin : g_cell
    logic ci, co;
    if (i == 0) begin : g_first
      assign ci = chain_q;
    end else begin : g_next
      assign ci = g_cell[i-1].co;
    end
    addsub_cell u_cell (
      .x    (a_sr[i]),
      .y    (b_sr[i]),
      .cin  (ci),
      .mode (mode_q),
      .s    (slice[i]),
      .cout (co)
    );
  end

  assign chain_out = g_cell[STEP-1].co;

  // New slice enters the result register from the MSB end.
  assign r_ext = {slice, r_sr};

  // Operand/result shift registers, chain bit and slice counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr    <= '0;
      b_sr    <= '0;
      r_sr    <= '0;
      mode_q  <= MODE_SUB;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      chain_q <= 1'b0;
      cnt_q   <= '0;
    end else if (load) begin
      a_sr    <= a;
      b_sr    <= b;
      mode_q  <= mode;
      a_msb_q <= a[WIDTH-1];
      b_msb_q <= b[WIDTH-1];
      chain_q <= 1'b0;
      cnt_q   <= '0;
    end else if (shift) begin
      a_sr    <= a_sr >> STEP;
      b_sr    <= b_sr >> STEP;
      r_sr    <= r_ext[WIDTH+STEP-1:STEP];
      chain_q <= chain_out;
      cnt_q   <= cnt_q + CW'(1);
    end
  end

  // Result, flags and done pulse, captured once in DONE and then held.
  always_ff @(posedge clk) begin
    if (rst) begin
      done   <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
      zero   <= 1'b0;
      neg    <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      done <= finish;
      if (finish) begin
        result <= r_sr;
        cout   <= chain_q;
        zero   <= (r_sr == '0);
        neg    <= r_sr[WIDTH-1];
        ovf    <= ovf_flag(mode_q, a_msb_q, b_msb_q, r_sr[WIDTH-1]);
      end
    end
  end

endmodule

// File: tb/tb_serial_addsub_unit.sv
// Bench for serial_addsub_unit: three builds (STEP=1,2,3 at WIDTH=6) share
// stimulus; an arithmetic model predicts every output on every cycle.
module tb_serial_addsub_unit;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic [5:0] res;
    logic       cout;
    logic       zero;
    logic       neg;
    logic       ovf;
  } obs_t;

  localparam int NCYC_T [3] = '{6, 3, 2};

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       start = 1'b0;
  logic       mode  = 1'b0;
  logic [5:0] a     = '0;
  logic [5:0] b     = '0;

  logic [2:0] busy_w, done_w, cout_w, zero_w, neg_w, ovf_w;
  logic [5:0] res_w [3];

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  serial_addsub_unit #(.WIDTH(6), .STEP(1)) u_s1 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .a(a), .b(b),
    .busy(busy_w[0]), .done(done_w[0]), .result(res_w[0]), .cout(cout_w[0]),
    .zero(zero_w[0]), .neg(neg_w[0]), .ovf(ovf_w[0])
  );

  serial_addsub_unit #(.WIDTH(6), .STEP(2)) u_s2 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .a(a), .b(b),
    .busy(busy_w[1]), .done(done_w[1]), .result(res_w[1]), .cout(cout_w[1]),
    .zero(zero_w[1]), .neg(neg_w[1]), .ovf(ovf_w[1])
  );

  serial_addsub_unit #(.WIDTH(6), .STEP(3)) u_s3 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .a(a), .b(b),
    .busy(busy_w[2]), .done(done_w[2]), .result(res_w[2]), .cout(cout_w[2]),
    .zero(zero_w[2]), .neg(neg_w[2]), .ovf(ovf_w[2])
  );

  // Plain-integer prediction of result and flags for one operation.
  function automatic obs_t predict(input logic m, input logic [5:0] x, input logic [5:0] y);
    obs_t o;
    int ux, uy, sx, sy, r, s;
    ux = int'(x);
    uy = int'(y);
    sx = (ux >= 32) ? ux - 64 : ux;
    sy = (uy >= 32) ? uy - 64 : uy;
    o = '0;
    if (m) begin
      r = ux + uy;
      s = sx + sy;
      o.cout = (r > 63);
    end else begin
      r = ux - uy;
      s = sx - sy;
      o.cout = (ux < uy);
    end
    o.res  = 6'(r & 63);
    o.zero = ((r & 63) == 0);
    o.neg  = ((r & 32) != 0);
    o.ovf  = (s > 31) || (s < -32);
    return o;
  endfunction

  // Model state: edge count, accepted-start edge and visible/pending results.
  int   cyc = 0;
  bit   mvalid = 1'b0;
  bit   infl [3];
  int   kst  [3];
  obs_t vis  [3];
  obs_t pend [3];

  always @(posedge clk) begin
    cyc++;
    for (int d = 0; d < 3; d++) begin
      if (rst) begin
        infl[d] = 1'b0;
        vis[d]  = '0;
        mvalid  = 1'b1;
      end else begin
        if (infl[d] && cyc == kst[d] + NCYC_T[d] + 1)
          vis[d] = pend[d];
        if (start && (!infl[d] || cyc >= kst[d] + NCYC_T[d] + 2)) begin
          kst[d]  = cyc;
          infl[d] = 1'b1;
          pend[d] = predict(mode, a, b);
        end
      end
    end
  end

  // Compare every build against the model on every cycle.
  always @(negedge clk) begin
    if (mvalid) begin
      for (int d = 0; d < 3; d++) begin
        obs_t o_act, o_exp;
        o_exp      = vis[d];
        o_exp.busy = infl[d] && cyc >= kst[d] && cyc <= kst[d] + NCYC_T[d] - 1;
        o_exp.done = infl[d] && cyc == kst[d] + NCYC_T[d] + 1;
        o_act = {busy_w[d], done_w[d], res_w[d], cout_w[d], zero_w[d], neg_w[d], ovf_w[d]};
        n_vec++;
        if (o_act !== o_exp) begin
          n_bad++;
          $display("FAIL model step%0d cyc=%0d: got busy=%b done=%b res=%b c=%b z=%b n=%b v=%b, expected busy=%b done=%b res=%b c=%b z=%b n=%b v=%b",
                   d + 1, cyc, o_act.busy, o_act.done, o_act.res, o_act.cout, o_act.zero,
                   o_act.neg, o_act.ovf, o_exp.busy, o_exp.done, o_exp.res, o_exp.cout,
                   o_exp.zero, o_exp.neg, o_exp.ovf);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    n_vec++;
    if (got !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, got, expv);
    end
  endtask

  // Literal check of the STEP=1 build: {done, result, cout, zero, neg, ovf}.
  task automatic chk_out(input string name, input logic [5:0] r, input logic c,
                         input logic z, input logic n, input logic v);
    chk(name, {22'd0, done_w[0], res_w[0], cout_w[0], zero_w[0], neg_w[0], ovf_w[0]},
        {22'd0, 1'b1, r, c, z, n, v});
  endtask

  // Issue one operation; returns edges counted from the start-sampling edge
  // until done is seen on the STEP=1 build (bounded).
  task automatic run_op(input logic m, input logic [5:0] x, input logic [5:0] y,
                        output int edges);
    @(negedge clk);
    mode  = m;
    a     = x;
    b     = y;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    edges = 1;
    while (!done_w[0] && edges < 20) begin
      @(negedge clk);
      edges++;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int e;
    int nd;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset outputs",
        {23'd0, busy_w[0], done_w[0], res_w[0], cout_w[0], zero_w[0], neg_w[0], ovf_w[0]}, '0);

    // 3 - 3
    run_op(1'b0, 6'b000011, 6'b000011, e);
    chk("t1 latency", e, 8);
    chk_out("t1 sub 3-3", 6'b000000, 1'b0, 1'b1, 1'b0, 1'b0);

    // 1 - 2
    run_op(1'b0, 6'b000001, 6'b000010, e);
    chk_out("t2 sub 1-2", 6'b111111, 1'b1, 1'b0, 1'b1, 1'b0);

    // -32 - 1 and 31 + 1
    run_op(1'b0, 6'b100000, 6'b000001, e);
    chk_out("t3 sub ovf", 6'b011111, 1'b0, 1'b0, 1'b0, 1'b1);
    run_op(1'b1, 6'b011111, 6'b000001, e);
    chk_out("t3 add ovf", 6'b100000, 1'b0, 1'b0, 1'b1, 1'b1);

    // 63 + 1
    run_op(1'b1, 6'b111111, 6'b000001, e);
    chk_out("t4 add wrap", 6'b000000, 1'b1, 1'b1, 1'b0, 1'b0);

    // 5 - 3 with a start pulse and operand changes while running
    @(negedge clk);
    mode  = 1'b0;
    a     = 6'd5;
    b     = 6'd3;
    start = 1'b1;
    nd    = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (done_w[0]) nd++;
      start = (i == 1);
      if (i == 1) begin
        a    = 6'd7;
        b    = 6'd7;
        mode = 1'b1;
      end
      if (i == 2) begin
        a = 6'h2a;
        b = 6'h15;
      end
    end
    chk("t5 done count", nd, 1);
    chk("t5 result held", {26'd0, res_w[0]}, 32'd2);

    // Abort mid-run with reset
    @(negedge clk);
    mode  = 1'b0;
    a     = 6'd5;
    b     = 6'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5 abort outputs",
        {23'd0, busy_w[0], done_w[0], res_w[0], cout_w[0], zero_w[0], neg_w[0], ovf_w[0]}, '0);
    nd = 0;
    repeat (12) begin
      @(negedge clk);
      if (done_w[0]) nd++;
    end
    chk("t5 no done after abort", nd, 0);
    run_op(1'b1, 6'd9, 6'd4, e);
    chk("t5 restart latency", e, 8);
    chk_out("t5 restart add 9+4", 6'b001101, 1'b0, 1'b0, 1'b0, 1'b0);

    // Random operations, back to back, on all three builds
    for (int i = 0; i < 200; i++) begin
      run_op(1'($urandom), 6'($urandom), 6'($urandom), e);
      chk("rand latency", e, 8);
    end

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
